jump_ctrl: RTL and testbench
============================

JUMP_CTRL -- requirements
Module: jump_ctrl

Interface
REQ-001 Parameter CHARGE_DIV, default 4: CHARGE cycles per velocity step.
REQ-002 Parameter CHARGE_STEP, default 1: velocity increment per step.
REQ-003 Parameter V_MIN, default 16: velocity loaded on CHARGE entry.
REQ-004 Parameter V_MAX, default 1023: velocity saturation ceiling.
REQ-005 Parameter FLIGHT_TIMEOUT, default 4096: maximum FLIGHT cycles before failure.
REQ-006 clk_jump  in  1  sole clock; all state on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 btn  in  1  debounced jump-button level, synchronous to clk_jump.
REQ-009 i_done  in  1  landing flag from jump datapath.
REQ-010 i_dist  in  11  horizontal distance from jump datapath.
REQ-011 i_gap_min, i_gap_max  in  11 each  inclusive landing window for the target platform.
REQ-012 o_jump_en  out  1  enable to jump datapath.
REQ-013 o_v_init  out  11  initial velocity to jump datapath.
REQ-014 o_score  out  16  successful-landing count.
REQ-015 o_land_ok  out  1  one-cycle pulse on successful landing.
REQ-016 o_game_over  out  1  high while in OVER.
REQ-017 o_state  out  3  current state encoding, for debug/display.

Function
REQ-018 The FSM SHALL have states IDLE=0, CHARGE=1, FLIGHT=2, LAND=3, COOL=4, OVER=5; all outputs SHALL be registered.
REQ-019 IDLE: btn=1 SHALL move to CHARGE next cycle, loading velocity register to V_MIN and clearing the divider counter.
REQ-020 CHARGE: each CHARGE_DIV consecutive cycles with btn=1 SHALL add CHARGE_STEP to velocity, saturating at V_MAX with no wrap.
REQ-021 CHARGE with btn=0 SHALL move to FLIGHT; o_jump_en SHALL rise on the same edge, and o_v_init SHALL hold the final velocity unchanged through FLIGHT and LAND.
REQ-022 FLIGHT: i_done=1 SHALL move to LAND, capturing i_dist; a flight-cycle counter reaching FLIGHT_TIMEOUT without i_done SHALL move to OVER with o_jump_en=0.
REQ-023 LAND (one cycle): captured distance within [i_gap_min, i_gap_max] inclusive SHALL increment o_score (saturating at 16'hFFFF), pulse o_land_ok for exactly one cycle, and move to COOL; otherwise SHALL move to OVER.
REQ-024 COOL: o_jump_en SHALL be 0; the FSM SHALL return to IDLE on the first cycle i_done=0.
REQ-025 OVER: o_jump_en=0, o_game_over=1, o_score held; a btn falling edge SHALL clear o_score to 0 and return to IDLE.
REQ-026 btn SHALL be ignored in FLIGHT, LAND and COOL.
REQ-027 i_gap_min > i_gap_max SHALL be treated as an empty window, so every landing fails.
REQ-028 If i_done and the timeout occur on the same cycle, i_done SHALL take priority.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, o_jump_en=0, o_v_init=0, o_score=0, o_land_ok=0, o_game_over=0 and clear all counters, including mid-FLIGHT.
REQ-030 After rst_n rises, the first transition SHALL occur no earlier than the next clk_jump edge.

Structure
REQ-031 State encoding and parameter defaults SHALL reside in a shared package jump_pkg.
REQ-032 The divider, velocity accumulator and saturation logic SHALL be a sub-module jump_charge; all other logic SHALL reside in jump_ctrl.

Verification
REQ-033 Reset: assert rst_n=0 mid-operation -> all outputs 0 and o_state=0 without waiting for a clock edge.
REQ-034 Hold btn 40 cycles (defaults) -> o_v_init=26 at release; o_jump_en=1 on the release edge.
REQ-035 Jump stub returns i_done with i_dist=300 and window [250,350] -> o_score 0->1, one-cycle o_land_ok, IDLE once i_done=0.
REQ-036 i_dist=400, same window -> OVER, o_game_over=1, score held; btn press then release -> o_score=0, IDLE.
REQ-037 Hold btn 5000 cycles -> o_v_init=1023 with no wrap.
REQ-038 No i_done for 4096 FLIGHT cycles -> OVER; i_done and timeout on the same cycle -> LAND.

Source files
------------

// File: rtl/jump_pkg.sv
// Shared state encoding, bus widths and parameter defaults for the jump controller.
// Also hosts the saturating velocity adder used by the charge accumulator.
package jump_pkg;

    localparam int VEL_W   = 11;
    localparam int DIST_W  = 11;
    localparam int SCORE_W = 16;

    localparam int unsigned CHARGE_DIV_DEF     = 4;
    localparam int unsigned CHARGE_STEP_DEF    = 1;
    localparam int unsigned V_MIN_DEF          = 16;
    localparam int unsigned V_MAX_DEF          = 1023;
    localparam int unsigned FLIGHT_TIMEOUT_DEF = 4096;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHARGE = 3'd1,
        ST_FLIGHT = 3'd2,
        ST_LAND   = 3'd3,
        ST_COOL   = 3'd4,
        ST_OVER   = 3'd5
    } state_e;

    // The sum is formed 32 bits wide so it can never wrap before the ceiling check.
    function automatic logic [VEL_W-1:0] vel_sat_add(input logic [VEL_W-1:0] v,
                                                     input int unsigned step,
                                                     input int unsigned vmax);
        int unsigned sum;
        sum = 32'(v) + step;
        if (sum > vmax) begin
            return VEL_W'(vmax);
        end
        return sum[VEL_W-1:0];
    endfunction

endpackage

// File: rtl/jump_ctrl_if.sv
// Link between the jump controller and the jump datapath that models the flight.
// The controller owns the enable and launch velocity; the datapath reports landing.
interface jump_ctrl_if;
    import jump_pkg::*;

    logic              o_jump_en;
    logic [VEL_W-1:0]  o_v_init;
    logic              i_done;
    logic [DIST_W-1:0] i_dist;

    modport master (
        output o_jump_en,
        output o_v_init,
        input  i_done,
        input  i_dist
    );

    modport slave (
        input  o_jump_en,
        input  o_v_init,
        output i_done,
        output i_dist
    );

endinterface

// File: rtl/jump_charge.sv
// Charge accumulator: a divider paces velocity steps while the button is held,
// and the velocity saturates at V_MAX instead of wrapping.
module jump_charge
    import jump_pkg::*;
#(
    parameter int unsigned CHARGE_DIV  = CHARGE_DIV_DEF,
    parameter int unsigned CHARGE_STEP = CHARGE_STEP_DEF,
    parameter int unsigned V_MIN       = V_MIN_DEF,
    parameter int unsigned V_MAX       = V_MAX_DEF
) (
    input  logic             clk_jump,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             run_i,
    output logic [VEL_W-1:0] vel_o
);

    localparam int unsigned      DIV_W    = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CHARGE_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [VEL_W-1:0] vel_q, vel_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        div_d = div_q;
        vel_d = vel_q;
        if (load_i) begin
            div_d = '0;
            vel_d = VEL_W'(V_MIN);
        end else if (run_i) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                vel_d = vel_sat_add(vel_q, CHARGE_STEP, V_MAX);
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_jump or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            vel_q <= '0;
        end else begin
            div_q <= div_d;
            vel_q <= vel_d;
        end
    end

    assign vel_o = vel_q;

endmodule

// File: rtl/jump_ctrl.sv
// Jump game controller: charge, flight supervision, landing judgement and scoring.
// All outputs come straight from flops so the display and datapath see clean levels.
module jump_ctrl
    import jump_pkg::*;
#(
    parameter int unsigned CHARGE_DIV     = CHARGE_DIV_DEF,
    parameter int unsigned CHARGE_STEP    = CHARGE_STEP_DEF,
    parameter int unsigned V_MIN          = V_MIN_DEF,
    parameter int unsigned V_MAX          = V_MAX_DEF,
    parameter int unsigned FLIGHT_TIMEOUT = FLIGHT_TIMEOUT_DEF
) (
    input  logic               clk_jump,
    input  logic               rst_n,
    input  logic               btn,
    jump_ctrl_if.master        dp,
    input  logic [DIST_W-1:0]  i_gap_min,
    input  logic [DIST_W-1:0]  i_gap_max,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_land_ok,
    output logic               o_game_over,
    output logic [2:0]         o_state
);

    localparam int unsigned     FC_W    = $clog2(FLIGHT_TIMEOUT + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLIGHT_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic               jump_en_q, jump_en_d;
    logic [VEL_W-1:0]   v_init_q, v_init_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               land_ok_q, land_ok_d;
    logic               game_over_q, game_over_d;
    logic [DIST_W-1:0]  dist_q, dist_d;
    logic [FC_W-1:0]    fc_q, fc_d;
    logic               btn_prev_q, btn_prev_d;

    logic               charge_load;
    logic               charge_run;
    logic [VEL_W-1:0]   vel;
    logic               in_window;

    jump_charge #(
        .CHARGE_DIV  (CHARGE_DIV),
        .CHARGE_STEP (CHARGE_STEP),
        .V_MIN       (V_MIN),
        .V_MAX       (V_MAX)
    ) u_charge (
        .clk_jump (clk_jump),
        .rst_n    (rst_n),
        .load_i   (charge_load),
        .run_i    (charge_run),
        .vel_o    (vel)
    );

    // An inverted window (min > max) can never satisfy both bounds, so it is empty.
    assign in_window = (dist_q >= i_gap_min) && (dist_q <= i_gap_max);

    always_comb begin
        state_d     = state_q;
        jump_en_d   = jump_en_q;
        v_init_d    = v_init_q;
        score_d     = score_q;
        land_ok_d   = 1'b0;
        dist_d      = dist_q;
        fc_d        = fc_q;
        btn_prev_d  = btn;
        charge_load = 1'b0;
        charge_run  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                jump_en_d = 1'b0;
                if (btn) begin
                    state_d     = ST_CHARGE;
                    charge_load = 1'b1;
                end
            end
            ST_CHARGE: begin
                if (btn) begin
                    charge_run = 1'b1;
                end else begin
                    state_d   = ST_FLIGHT;
                    jump_en_d = 1'b1;
                    v_init_d  = vel;
                    fc_d      = '0;
                end
            end
            ST_FLIGHT: begin
                // Landing wins over a timeout expiring on the same cycle.
                if (dp.i_done) begin
                    state_d = ST_LAND;
                    dist_d  = dp.i_dist;
                end else if (fc_q == FC_LAST) begin
                    state_d   = ST_OVER;
                    jump_en_d = 1'b0;
                end else begin
                    fc_d = fc_q + 1'b1;
                end
            end
            ST_LAND: begin
                jump_en_d = 1'b0;
                if (in_window) begin
                    state_d   = ST_COOL;
                    land_ok_d = 1'b1;
                    score_d   = (score_q == '1) ? score_q : score_q + 1'b1;
                end else begin
                    state_d = ST_OVER;
                end
            end
            ST_COOL: begin
                jump_en_d = 1'b0;
                if (!dp.i_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OVER: begin
                jump_en_d = 1'b0;
                if (btn_prev_q && !btn) begin
                    state_d = ST_IDLE;
                    score_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                jump_en_d = 1'b0;
            end
        endcase

        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk_jump or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            jump_en_q   <= 1'b0;
            v_init_q    <= '0;
            score_q     <= '0;
            land_ok_q   <= 1'b0;
            game_over_q <= 1'b0;
            dist_q      <= '0;
            fc_q        <= '0;
            btn_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            jump_en_q   <= jump_en_d;
            v_init_q    <= v_init_d;
            score_q     <= score_d;
            land_ok_q   <= land_ok_d;
            game_over_q <= game_over_d;
            dist_q      <= dist_d;
            fc_q        <= fc_d;
            btn_prev_q  <= btn_prev_d;
        end
    end

    assign dp.o_jump_en = jump_en_q;
    assign dp.o_v_init  = v_init_q;
    assign o_score      = score_q;
    assign o_land_ok    = land_ok_q;
    assign o_game_over  = game_over_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed bench for jump_ctrl: charge, landing, failure, saturation, timeout and reset.
// Inputs change and outputs are sampled on the falling edge, away from the active edge.
module tb_jump_ctrl;
    import jump_pkg::*;

    logic               clk_jump = 1'b0;
    logic               rst_n;
    logic               btn;
    logic [DIST_W-1:0]  i_gap_min, i_gap_max;
    logic [SCORE_W-1:0] o_score;
    logic               o_land_ok, o_game_over;
    logic [2:0]         o_state;

    int total = 0;
    int bad   = 0;

    jump_ctrl_if dp_if ();

    jump_ctrl u_dut (
        .clk_jump    (clk_jump),
        .rst_n       (rst_n),
        .btn         (btn),
        .dp          (dp_if),
        .i_gap_min   (i_gap_min),
        .i_gap_max   (i_gap_max),
        .o_score     (o_score),
        .o_land_ok   (o_land_ok),
        .o_game_over (o_game_over),
        .o_state     (o_state)
    );

    always #5 clk_jump = ~clk_jump;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_jump);
    endtask

    // IDLE -> CHARGE on one edge, release on the next: launches at V_MIN.
    task automatic quick_launch();
        btn = 1'b1;
        step(1);
        btn = 1'b0;
        step(1);
    endtask

    initial begin
        rst_n           = 1'b0;
        btn             = 1'b0;
        dp_if.i_done    = 1'b0;
        dp_if.i_dist    = '0;
        i_gap_min       = 11'd250;
        i_gap_max       = 11'd350;
        step(2);
        check("rst_state",   32'(o_state), 32'd0);
        check("rst_jump_en", 32'(dp_if.o_jump_en), 32'd0);
        check("rst_v_init",  32'(dp_if.o_v_init), 32'd0);
        check("rst_score",   32'(o_score), 32'd0);
        check("rst_over",    32'(o_game_over), 32'd0);
        check("rst_land_ok", 32'(o_land_ok), 32'd0);
        rst_n = 1'b1;
        step(1);
        check("idle_hold", 32'(o_state), 32'd0);

        // 40 charge cycles at DIV=4 give ten steps: 16 + 10 = 26.
        btn = 1'b1;
        step(1);
        check("charge_entry", 32'(o_state), 32'd1);
        step(40);
        check("charge_stay",   32'(o_state), 32'd1);
        check("charge_no_en",  32'(dp_if.o_jump_en), 32'd0);
        btn = 1'b0;
        step(1);
        check("launch_state",  32'(o_state), 32'd2);
        check("launch_en",     32'(dp_if.o_jump_en), 32'd1);
        check("launch_v_init", 32'(dp_if.o_v_init), 32'd26);
        btn = 1'b1;
        step(5);
        check("flight_btn_ignored", 32'(o_state), 32'd2);
        check("flight_v_hold",      32'(dp_if.o_v_init), 32'd26);
        btn = 1'b0;

        // Successful landing at 300 inside [250,350].
        dp_if.i_dist = 11'd300;
        dp_if.i_done = 1'b1;
        step(1);
        check("land_state",  32'(o_state), 32'd3);
        check("land_v_hold", 32'(dp_if.o_v_init), 32'd26);
        step(1);
        check("cool_state",   32'(o_state), 32'd4);
        check("cool_score",   32'(o_score), 32'd1);
        check("cool_land_ok", 32'(o_land_ok), 32'd1);
        check("cool_en_off",  32'(dp_if.o_jump_en), 32'd0);
        step(1);
        check("cool_wait_done", 32'(o_state), 32'd4);
        check("land_ok_pulse",  32'(o_land_ok), 32'd0);
        dp_if.i_done = 1'b0;
        step(1);
        check("cool_to_idle", 32'(o_state), 32'd0);

        // Landing on the upper bound counts as a hit.
        quick_launch();
        check("edge_v_init", 32'(dp_if.o_v_init), 32'd16);
        dp_if.i_dist = 11'd350;
        dp_if.i_done = 1'b1;
        step(2);
        check("edge_hit_state", 32'(o_state), 32'd4);
        check("edge_hit_score", 32'(o_score), 32'd2);
        dp_if.i_done = 1'b0;
        step(1);

        // Miss at 400: game over with score held; press and release to restart.
        quick_launch();
        dp_if.i_dist = 11'd400;
        dp_if.i_done = 1'b1;
        step(2);
        check("miss_state",   32'(o_state), 32'd5);
        check("miss_over",    32'(o_game_over), 32'd1);
        check("miss_score",   32'(o_score), 32'd2);
        check("miss_en_off",  32'(dp_if.o_jump_en), 32'd0);
        dp_if.i_done = 1'b0;
        btn = 1'b1;
        step(2);
        check("over_press_held", 32'(o_state), 32'd5);
        check("over_score_held", 32'(o_score), 32'd2);
        btn = 1'b0;
        step(1);
        check("restart_state", 32'(o_state), 32'd0);
        check("restart_score", 32'(o_score), 32'd0);
        check("restart_over",  32'(o_game_over), 32'd0);

        // Inverted window: a distance between the bounds still misses.
        i_gap_min = 11'd350;
        i_gap_max = 11'd250;
        quick_launch();
        dp_if.i_dist = 11'd300;
        dp_if.i_done = 1'b1;
        step(2);
        check("empty_window", 32'(o_state), 32'd5);
        dp_if.i_done = 1'b0;
        i_gap_min = 11'd250;
        i_gap_max = 11'd350;
        btn = 1'b1;
        step(1);
        btn = 1'b0;
        step(1);

        // Long charge saturates at V_MAX without wrapping.
        btn = 1'b1;
        step(1);
        step(5000);
        btn = 1'b0;
        step(1);
        check("sat_v_init", 32'(dp_if.o_v_init), 32'd1023);

        // No landing for 4096 flight cycles ends the game.
        step(4095);
        check("timeout_minus1", 32'(o_state), 32'd2);
        step(1);
        check("timeout_state", 32'(o_state), 32'd5);
        check("timeout_en",    32'(dp_if.o_jump_en), 32'd0);
        check("timeout_over",  32'(o_game_over), 32'd1);
        btn = 1'b1;
        step(1);
        btn = 1'b0;
        step(1);

        // Landing on the timeout cycle takes priority.
        quick_launch();
        step(4095);
        dp_if.i_dist = 11'd300;
        dp_if.i_done = 1'b1;
        step(1);
        check("done_beats_timeout", 32'(o_state), 32'd3);
        step(1);
        check("tie_score", 32'(o_score), 32'd1);
        dp_if.i_done = 1'b0;
        step(1);
        check("tie_idle", 32'(o_state), 32'd0);

        // Asynchronous reset mid-flight, observed before any clock edge.
        quick_launch();
        step(3);
        check("pre_reset_flight", 32'(o_state), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_state",   32'(o_state), 32'd0);
        check("async_en",      32'(dp_if.o_jump_en), 32'd0);
        check("async_v_init",  32'(dp_if.o_v_init), 32'd0);
        check("async_score",   32'(o_score), 32'd0);
        check("async_over",    32'(o_game_over), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
        check("post_reset_idle", 32'(o_state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
